sample_filler_mc: RTL

SAMPLE_FILLER_MC -- requirements
Module: sample_filler_mc

---
 rtl/sample_filler_mc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sample_filler_mc.sv
// Multi-channel region filler: grants one requesting channel (round-robin) and writes its sample CICLI times.
// Latency: first write one cycle after the granted dav_ is seen released; CICLI back-to-back writes follow.
// Backpressure: all rfd bits drop from the grant to the end of the fill; other requests wait in IDLE.
module sample_filler_mc #(
    parameter int NCH       = 2,
    parameter int DATA_W    = 8,
    parameter int N_W       = 4,
    parameter int CICLI_LOG = 10,
    localparam int ADDR_W   = N_W + CICLI_LOG,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        dav_,
    output logic [NCH-1:0]        rfd,
    input  logic [NCH*DATA_W-1:0] d,
    input  logic [NCH*N_W-1:0]    enne,
    input  logic [NCH-1:0]        mode,
    output logic [ADDR_W-1:0]     a,
    output logic [DATA_W-1:0]     campione,
    output logic                  wr,
    output logic [CH_W-1:0]       ch
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        FILL     = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Per-channel views of the packed input buses
    logic [DATA_W-1:0] d_arr    [NCH];
    logic [N_W-1:0]    enne_arr [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign d_arr[gi]    = d[gi*DATA_W +: DATA_W];
        assign enne_arr[gi] = enne[gi*N_W +: N_W];
    end

    // Request captured at grant time; inputs are ignored afterwards
    logic [DATA_W-1:0] d_lat;
    logic [N_W-1:0]    enne_lat;
    logic              mode_lat;

    // Round-robin search start (channel after the last grant)
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_nxt;
    logic [CH_W:0]     rr_sum;

    logic              req_hit;
    logic [CH_W-1:0]   pick;
    logic [CH_W:0]     cand;

    // rfd is all zeros only in the first IDLE cycle after reset, which must not grant
    logic              armed;
    logic              last_wr;
    logic              grant;

    logic [NCH-1:0]    rfd_nxt;
    logic              wr_nxt;
    logic [ADDR_W-1:0] a_nxt;
    logic [DATA_W-1:0] campione_nxt;
    logic [CH_W-1:0]   ch_nxt;

    assign armed   = rfd[0];
    assign last_wr = wr && (a[CICLI_LOG-1:0] == {CICLI_LOG{1'b1}});

    // Round-robin pick: scan offsets high to low so the nearest requester wins
    always_comb begin
        req_hit = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(off);
            if (cand >= (CH_W+1)'(NCH)) begin
                cand = cand - (CH_W+1)'(NCH);
            end
            if (!dav_[cand[CH_W-1:0]]) begin
                req_hit = 1'b1;
                pick    = cand[CH_W-1:0];
            end
        end
    end

    // Next search start: the channel after the one being granted
    always_comb begin
        rr_sum = {1'b0, pick} + {{CH_W{1'b0}}, 1'b1};
        rr_nxt = (rr_sum >= (CH_W+1)'(NCH)) ? '0 : rr_sum[CH_W-1:0];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (armed && req_hit) begin
                    state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (dav_[ch]) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (last_wr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        rfd_nxt      = rfd;
        wr_nxt       = wr;
        a_nxt        = a;
        campione_nxt = campione;
        ch_nxt       = ch;
        grant        = 1'b0;
        case (state)
            IDLE: begin
                rfd_nxt = '1;
                wr_nxt  = 1'b0;
                if (armed && req_hit) begin
                    grant   = 1'b1;
                    rfd_nxt = '0;
                    ch_nxt  = pick;
                end
            end
            WAIT_REL: begin
                rfd_nxt = '0;
                wr_nxt  = 1'b0;
                if (dav_[ch]) begin
                    wr_nxt       = 1'b1;
                    a_nxt        = {enne_lat, {CICLI_LOG{1'b0}}};
                    campione_nxt = d_lat;
                end
            end
            FILL: begin
                if (last_wr) begin
                    // Stop at the region's last word; address never crosses into the next region
                    wr_nxt  = 1'b0;
                    rfd_nxt = '1;
                end else begin
                    a_nxt = {a[ADDR_W-1:CICLI_LOG], a[CICLI_LOG-1:0] + CICLI_LOG'(1)};
                    if (mode_lat) begin
                        campione_nxt = campione + DATA_W'(1);
                    end
                end
            end
            default: begin
                rfd_nxt = '0;
                wr_nxt  = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            rfd      <= '0;
            wr       <= 1'b0;
            a        <= '0;
            campione <= '0;
            ch       <= '0;
        end else begin
            rfd      <= rfd_nxt;
            wr       <= wr_nxt;
            a        <= a_nxt;
            campione <= campione_nxt;
            ch       <= ch_nxt;
        end
    end

    // Capture the granted channel's request and advance the round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            d_lat    <= '0;
            enne_lat <= '0;
            mode_lat <= 1'b0;
            rr_ptr   <= '0;
        end else if (grant) begin
            d_lat    <= d_arr[pick];
            enne_lat <= enne_arr[pick];
            mode_lat <= mode[pick];
            rr_ptr   <= rr_nxt;
        end
    end

endmodule
